uart_rx: RTL and testbench

Oversampling UART receiver: recovers 8N1-style serial frames from the asynchronous `rx` line and presents each received word with a one-cycle completion pulse and a framing-error flag. It uses the shared 16x baud tick (`sTick`) that also drives the transmitter. It sits between the pad-side `rx` input and the receive FIFO or host logic.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling constants and
// the 2-of-3 vote helper used by the optional majority sampler.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned START_MID  = 7;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pad plus a falling-edge
// detector. Every flop resets to the idle-high line level so that no
// spurious edge appears when reset is released.
module uart_rx_sync (
    input  logic clk,
    input  logic resetn,
    input  logic rx,
    output logic rxS,
    output logic fallEdge
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rxS      = sync_q;
    assign fallEdge = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (start bit, dBits data bits LSB first, stop).
// Uses the shared 16x baud tick sTick; one rxDone pulse per frame.
// Optional build macro UART_RX_MAJORITY_EN: each sample becomes a 2-of-3
// vote over the last three sTick samples of the bit; timing is unchanged.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned dBits   = 8,
    parameter int unsigned sbTicks = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sTick,
    input  logic             rx,
    output logic [dBits-1:0] dataOut,
    output logic             rxDone,
    output logic             frameErr
);

    localparam int unsigned NW = $clog2(dBits);

    logic rxS;
    logic fallEdge;

    uart_rx_sync u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .rx       (rx),
        .rxS      (rxS),
        .fallEdge (fallEdge)
    );

    uart_state_e      state_q, state_d;
    logic [3:0]       s_q, s_d;
    logic [NW-1:0]    n_q, n_d;
    logic [dBits-1:0] sh_q, sh_d;
    logic [dBits-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             sample;

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] vote_q, vote_d;

    // Vote over the two previous tick samples and the current one.
    assign sample = maj3({vote_q[1:0], rxS});
`else
    assign sample = rxS;
`endif

    // Next-state, counter, shift and output-register logic.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fallEdge) begin
                    s_d     = 4'd0;
                    state_d = START;
                end
            end
            START: begin
                if (sTick) begin
                    if (s_q == 4'(START_MID)) begin
                        if (!sample) begin
                            s_d     = 4'd0;
                            n_d     = '0;
                            state_d = DATA;
                        end else begin
                            // Start bit did not hold low: treat as a glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (sTick) begin
                    if (s_q == 4'(OVERSAMPLE - 1)) begin
                        s_d  = 4'd0;
                        sh_d = {sample, sh_q[dBits-1:1]};
                        if (n_q == NW'(dBits - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (sTick) begin
                    if (s_q == 4'(sbTicks - 1)) begin
                        data_d  = sh_q;
                        err_d   = ~sample;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_RX_MAJORITY_EN
    // Shift in one sample per tick while busy; clear on every state entry.
    always_comb begin
        vote_d = vote_q;
        if (sTick && state_q != IDLE) begin
            vote_d = {vote_q[1:0], rxS};
        end
        if (state_d != state_q) begin
            vote_d = 3'b000;
        end
    end

    // Vote register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vote_q <= 3'b000;
        end else begin
            vote_q <= vote_d;
        end
    end
`endif

    // Receiver state and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            s_q     <= 4'd0;
            n_q     <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign dataOut  = data_q;
    assign rxDone   = done_q;
    assign frameErr = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (dBits=8, sbTicks=16, sTick every 4 clk,
// 64 clk per bit). Honours UART_RX_MAJORITY_EN for the expected values.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       resetn;
    logic       sTick;
    logic       rx;
    logic [7:0] dataOut;
    logic       rxDone;
    logic       frameErr;

    always #5 clk = ~clk;

    uart_rx #(
        .dBits   (8),
        .sbTicks (16)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .sTick    (sTick),
        .rx       (rx),
        .dataOut  (dataOut),
        .rxDone   (rxDone),
        .frameErr (frameErr)
    );

    int   cyc;
    int   ticks;
    int   checks;
    int   errors;
    int   long_pulse;
    logic prev_done;

    logic [7:0] got_data[$];
    logic       got_err[$];
    int         got_tick[$];
    logic [7:0] exp_data[$];
    logic       exp_err[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clk of time: sTick every 4th clk, rxDone pulses captured on the way.
    task automatic step();
        @(negedge clk);
        cyc++;
        sTick = (cyc % 4 == 0);
        if (sTick) ticks++;
        if (rxDone) begin
            got_data.push_back(dataOut);
            got_err.push_back(frameErr);
            got_tick.push_back(ticks);
            if (prev_done) long_pulse++;
        end
        prev_done = rxDone;
    endtask

    // Wait for the clk on which sTick has just been raised.
    task automatic align();
        while (cyc % 4 != 0) step();
    endtask

    // Line waveform for a frame, one entry per clk, with an optional low glitch.
    function automatic logic [639:0] build_line(input logic [7:0] b, input logic stop,
                                                input int g_at, input int g_len);
        logic [9:0]   f;
        logic [639:0] l;
        f = {stop, b, 1'b0};
        for (int c = 0; c < 640; c++) begin
            l[c] = f[c/64];
            if (c >= g_at && c < g_at + g_len) l[c] = 1'b0;
        end
        return l;
    endfunction

    // Receiver decision for a bit whose sample tick reads line clk index idx.
    function automatic logic pick(input logic [639:0] l, input int idx);
`ifdef UART_RX_MAJORITY_EN
        logic a, b, c;
        a = l[idx-8];
        b = l[idx-4];
        c = l[idx];
        return (a & b) | (a & c) | (b & c);
`else
        return l[idx];
`endif
    endfunction

    // Sample ticks are 8, 24+16k and 152 ticks after the start tick; the
    // synchronizer means each reads the line as driven 2 clk earlier.
    task automatic model_line(input logic [639:0] l);
        logic [7:0] d;
        if (pick(l, 30) == 1'b0) begin
            for (int k = 0; k < 8; k++) d[k] = pick(l, 94 + 64 * k);
            exp_data.push_back(d);
            exp_err.push_back(~pick(l, 606));
        end
    endtask

    task automatic drive_line(input logic [639:0] l, input int n);
        for (int c = 0; c < n; c++) begin
            rx = l[c];
            step();
        end
    endtask

    task automatic send_line(input logic [639:0] l);
        align();
        model_line(l);
        drive_line(l, 640);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int g_at,
                              input int g_len);
        send_line(build_line(b, stop, g_at, g_len));
    endtask

    task automatic check_frames(input string tag);
        chk({tag, "_count"}, got_data.size(), exp_data.size());
        while (got_data.size() > 0 && exp_data.size() > 0) begin
            chk({tag, "_data"}, got_data.pop_front(), exp_data.pop_front());
            chk({tag, "_err"}, got_err.pop_front(), exp_err.pop_front());
        end
        got_data.delete();
        got_err.delete();
        got_tick.delete();
        exp_data.delete();
        exp_err.delete();
    endtask

    initial begin
        logic [639:0] l;
        logic [7:0]   b;
        logic         stop;
        int           gap;
        int           g_at;
        int           g_len;
        logic [7:0]   last;

        cyc = 0; ticks = 0; checks = 0; errors = 0; long_pulse = 0; prev_done = 1'b0;
        resetn = 1'b0;
        sTick  = 1'b0;
        rx     = 1'b1;

        // Reset state.
        repeat (5) step();
        chk("rst_data", dataOut, 8'h00);
        chk("rst_done", rxDone, 1'b0);
        chk("rst_err", frameErr, 1'b0);
        resetn = 1'b1;
        repeat (20) step();

        // Clean frames.
        send_frame(8'hA5, 1'b1, 0, 0);
        send_frame(8'h00, 1'b1, 0, 0);
        send_frame(8'hFF, 1'b1, 0, 0);
        repeat (10) step();
        check_frames("clean");

        // Random frames: random data, occasional bad stop, short data glitches.
        for (int i = 0; i < 8; i++) begin
            b     = 8'($urandom);
            stop  = ($urandom_range(0, 3) != 0);
            g_at  = $urandom_range(64, 575);
            g_len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
            send_frame(b, stop, g_at, g_len);
            gap = stop ? $urandom_range(0, 40) : $urandom_range(4, 40);
            rx  = 1'b1;
            repeat (gap) step();
        end
        repeat (8) step();
        check_frames("rand");

        // Back-to-back frames: pulses exactly one frame (160 ticks) apart.
        send_frame(8'h3C, 1'b1, 0, 0);
        send_frame(8'hC3, 1'b1, 0, 0);
        repeat (10) step();
        chk("b2b_gap", (got_tick.size() == 2) ? (got_tick[1] - got_tick[0]) : -1, 160);
        check_frames("b2b");

        // Start glitch: 5 ticks low, then a real frame.
        l = '1;
        l[19:0] = '0;
        send_line(l);
        repeat (200) step();
        check_frames("sglitch");
        send_frame(8'h5A, 1'b1, 0, 0);
        repeat (10) step();
        check_frames("after_sglitch");

        // Framing error, line then held low for 50 bit times.
        send_frame(8'h81, 1'b0, 0, 0);
        rx = 1'b0;
        repeat (50 * 64) step();
        chk("ferr_flag", (got_err.size() > 0) ? got_err[0] : 1'bx, 1'b1);
        check_frames("ferr");
        rx = 1'b1;
        repeat (16) step();
        send_frame(8'h66, 1'b1, 0, 0);
        repeat (10) step();
        check_frames("after_ferr");

        // Reset during data bit 4 of a frame.
        align();
        drive_line(build_line(8'h33, 1'b1, 0, 0), 64 * 5 + 20);
        resetn = 1'b0;
        #1;
        chk("midrst_data", dataOut, 8'h00);
        chk("midrst_done", rxDone, 1'b0);
        chk("midrst_err", frameErr, 1'b0);
        repeat (4) step();
        rx = 1'b1;
        repeat (4) step();
        resetn = 1'b1;
        repeat (128) step();
        check_frames("rst_abort");
        send_frame(8'h7E, 1'b1, 0, 0);
        repeat (10) step();
        check_frames("after_rst");

        // One-tick glitch at tick 15 of data bit 0 (the sample tick).
        send_frame(8'hFF, 1'b1, 92, 4);
        repeat (10) step();
        last = (got_data.size() > 0) ? got_data[got_data.size()-1] : 8'hxx;
`ifdef UART_RX_MAJORITY_EN
        chk("glitch15_value", last, 8'hFF);
`else
        chk("glitch15_value", last, 8'hFE);
`endif
        check_frames("glitch15");

        // One-tick glitch at tick 14 of data bit 0: masked in both builds.
        send_frame(8'hFF, 1'b1, 88, 4);
        repeat (10) step();
        last = (got_data.size() > 0) ? got_data[got_data.size()-1] : 8'hxx;
        chk("glitch14_value", last, 8'hFF);
        check_frames("glitch14");

        chk("pulse_width", long_pulse, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
